rob: RTL and testbench
======================

ROB -- requirements
Module: rob

Interface
REQ-001 The block SHALL take parameter ROB_SIZE_WIDTH, default `ROB_SIZE_WIDTH from the shared constants file; it sets the reorder-buffer entry count to 2^ROB_SIZE_WIDTH.
REQ-002 The block SHALL take parameter REG_NUM_WIDTH, default `REG_NUM_WIDTH; it sets the architectural register index width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk_in  in  1  clock
- rst_n_in  in  1  asynchronous active-low reset
- rdy_in  in  1  global ready; when low, all state holds
- dec_valid_in  in  1  decoder allocate request
- dec_kind_in  in  2  entry kind: 0 REG, 1 BRANCH, 2 STORE
- dec_rd_in  in  REG_NUM_WIDTH  destination register (REG only)
- rob_full_out  out  1  no free entry
- rob_tail_out  out  ROB_SIZE_WIDTH+1  tag granted to the current allocation, with MSB 0
- cdb_valid_in  in  1  result broadcast
- cdb_tag_in  in  ROB_SIZE_WIDTH+1  producing entry
- cdb_value_in  in  32  result value
- cdb_mispredict_in  in  1  branch resolved against its prediction
- cdb_target_in  in  32  correct next PC of the branch
- qry1_tag_in, qry2_tag_in  in  ROB_SIZE_WIDTH+1  operand tags to look up
- qry1_ready_out, qry2_ready_out  out  1  tagged result available
- qry1_value_out, qry2_value_out  out  32  tagged result value
- commit_valid_out  out  1  REG entry retired (to register file)
- commit_rd_out  out  REG_NUM_WIDTH  retired destination
- commit_value_out  out  32  retired value
- commit_tag_out  out  ROB_SIZE_WIDTH+1  retired entry tag
- store_commit_out  out  1  head STORE retired (to store buffer)
- need_flush_out  out  1  mispredict flush pulse
- flush_pc_out  out  32  redirect PC

Function
REQ-005 The block SHALL be a circular FIFO with head, tail and count registers; count is ROB_SIZE_WIDTH+1 bits wide; pointers wrap modulo 2^ROB_SIZE_WIDTH.
REQ-006 Each entry SHALL hold busy, ready, kind, rd, value, mispredict and target.
REQ-007 rob_full_out SHALL equal (registered count == 2^ROB_SIZE_WIDTH) and SHALL NOT bypass a same-cycle commit.
REQ-008 The block SHALL allocate at tail on the edge where dec_valid_in is high, rob_full_out is low and no flush is taken; the new entry is busy, not ready, and the tail advances by one.
REQ-009 An allocation request made while rob_full_out is high SHALL be ignored.
REQ-010 On cdb_valid_in, the addressed busy entry SHALL load value, mispredict and target, and set ready at the edge.
REQ-011 The tag value all-ones means "no dependency"; a CDB broadcast or query carrying it SHALL be ignored or return not-ready.
REQ-012 qryN_ready_out and qryN_value_out SHALL be combinational: the entry value if the entry's ready bit is set, else the CDB value if cdb_valid_in is high and cdb_tag_in matches, else not-ready with value 0.
REQ-013 The block SHALL retire at most one entry per cycle, and only when the head is busy and its registered ready bit is set; a CDB write to the head becomes committable the following cycle.
REQ-014 Retiring REG SHALL register commit_valid_out=1 with rd, value and tag for exactly one cycle.
REQ-015 Retiring STORE SHALL register store_commit_out=1 for exactly one cycle.
REQ-016 Retiring BRANCH without mispredict SHALL drive no output pulse.
REQ-017 Retiring BRANCH with mispredict SHALL register need_flush_out=1 and flush_pc_out=target for one cycle, and at the same edge set head=tail=count=0, clear all busy bits, and discard that cycle's allocation and CDB write.
REQ-018 Simultaneous allocate and non-flush commit SHALL leave count unchanged.
REQ-019 Allocation into an empty ROB SHALL NOT commit in the same cycle.
REQ-020 With rdy_in low, all state and registered outputs SHALL hold.

Reset
REQ-021 While rst_n_in is low, asynchronously: head, tail and count SHALL be 0; all busy and ready bits SHALL be 0; every commit, store and flush output SHALL be 0; flush_pc_out SHALL be 0. rob_full_out is 0 and rob_tail_out is 0 as a consequence.
REQ-022 Reset asserted mid-operation SHALL discard all entries with no commit pulse.

Structure
REQ-023 The entry-kind encodings and the no-dependency tag constant SHALL live in the shared constants file alongside ROB_SIZE_WIDTH and REG_NUM_WIDTH.
REQ-024 The block SHALL be a single module; a rob_query sub-module (one instance per query port) is permitted for the REQ-012 lookup.

Verification (ROB_SIZE_WIDTH=3)
REQ-025 Allocate 8 REG entries -> rob_full_out=1 after the 8th edge; a 9th request is ignored and the tail stays 0.
REQ-026 Allocate rd=5 at tag 0; broadcast tag 0 value 0x1234 -> one cycle later commit_valid_out=1, commit_rd_out=5, commit_value_out=0x1234, commit_tag_out=0.
REQ-027 Broadcast tag 2 before tag 0 -> no commit until tag 0 is ready; then tags 0,1,2 commit in order on consecutive cycles.
REQ-028 Head BRANCH with mispredict and target 0x80 -> need_flush_out=1, flush_pc_out=0x80, count=0 next cycle; a same-cycle allocation is dropped.
REQ-029 Full ROB with a ready head plus an allocate request -> the head commits, the allocation is rejected, and count=7.
REQ-030 With cdb tag 3 value 0x55 and qry1_tag_in=3 in the same cycle -> qry1_ready_out=1, qry1_value_out=0x55 combinationally; rst_n_in pulsed low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared ROB constants: default sizing, entry-kind encodings and the
// all-ones "no dependency" tag.
package rob_pkg;

  localparam int ROB_SIZE_WIDTH = 3;
  localparam int REG_NUM_WIDTH  = 5;

  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_STORE  = 2'd2
  } rob_kind_e;

  // Sliced down to the tag width at the point of use.
  localparam logic [31:0] NO_DEP_TAG = '1;

endpackage

// File: rtl/rob_query.sv
// Combinational operand lookup: a ready entry wins, otherwise forward
// a matching same-cycle CDB broadcast.
module rob_query #(
  parameter int ROB_SIZE_WIDTH = rob_pkg::ROB_SIZE_WIDTH
) (
  input  logic [ROB_SIZE_WIDTH:0]                         tag_i,
  input  logic [(1<<ROB_SIZE_WIDTH)-1:0]                  entry_ready_i,
  input  logic [(1<<ROB_SIZE_WIDTH)-1:0][31:0]            entry_value_i,
  input  logic                                            cdb_valid_i,
  input  logic [ROB_SIZE_WIDTH:0]                         cdb_tag_i,
  input  logic [31:0]                                     cdb_value_i,
  output logic                                            ready_o,
  output logic [31:0]                                     value_o
);
  import rob_pkg::*;

  localparam logic [ROB_SIZE_WIDTH:0] NO_DEP = NO_DEP_TAG[ROB_SIZE_WIDTH:0];

  logic [ROB_SIZE_WIDTH-1:0] idx;
  assign idx = tag_i[ROB_SIZE_WIDTH-1:0];

  always_comb begin
    ready_o = 1'b0;
    value_o = '0;
    if (tag_i != NO_DEP) begin
      if (entry_ready_i[idx]) begin
        ready_o = 1'b1;
        value_o = entry_value_i[idx];
      end else if (cdb_valid_i && (cdb_tag_i == tag_i)) begin
        ready_o = 1'b1;
        value_o = cdb_value_i;
      end
    end
  end

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order allocate at tail, out-of-order completion via
// CDB, in-order retire at head with a full flush on a mispredicted branch.
module rob #(
  parameter int ROB_SIZE_WIDTH = rob_pkg::ROB_SIZE_WIDTH,
  parameter int REG_NUM_WIDTH  = rob_pkg::REG_NUM_WIDTH
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      dec_valid_in,
  input  logic [1:0]                dec_kind_in,
  input  logic [REG_NUM_WIDTH-1:0]  dec_rd_in,
  output logic                      rob_full_out,
  output logic [ROB_SIZE_WIDTH:0]   rob_tail_out,
  input  logic                      cdb_valid_in,
  input  logic [ROB_SIZE_WIDTH:0]   cdb_tag_in,
  input  logic [31:0]               cdb_value_in,
  input  logic                      cdb_mispredict_in,
  input  logic [31:0]               cdb_target_in,
  input  logic [ROB_SIZE_WIDTH:0]   qry1_tag_in,
  input  logic [ROB_SIZE_WIDTH:0]   qry2_tag_in,
  output logic                      qry1_ready_out,
  output logic                      qry2_ready_out,
  output logic [31:0]               qry1_value_out,
  output logic [31:0]               qry2_value_out,
  output logic                      commit_valid_out,
  output logic [REG_NUM_WIDTH-1:0]  commit_rd_out,
  output logic [31:0]               commit_value_out,
  output logic [ROB_SIZE_WIDTH:0]   commit_tag_out,
  output logic                      store_commit_out,
  output logic                      need_flush_out,
  output logic [31:0]               flush_pc_out
);
  import rob_pkg::*;

  localparam int DEPTH = 1 << ROB_SIZE_WIDTH;
  localparam logic [ROB_SIZE_WIDTH:0] FULL_CNT = (ROB_SIZE_WIDTH+1)'(DEPTH);
  localparam logic [ROB_SIZE_WIDTH:0] NO_DEP   = NO_DEP_TAG[ROB_SIZE_WIDTH:0];

  logic [ROB_SIZE_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_SIZE_WIDTH:0]   count_q, count_d;
  logic [DEPTH-1:0]          busy_q, busy_d, ready_q, ready_d;

  rob_kind_e                 kind_q    [DEPTH];
  logic [REG_NUM_WIDTH-1:0]  rd_q      [DEPTH];
  logic [DEPTH-1:0][31:0]    value_q;
  logic [DEPTH-1:0]          mispred_q;
  logic [31:0]               target_q  [DEPTH];

  logic                      commit_valid_q, store_commit_q, need_flush_q;
  logic [REG_NUM_WIDTH-1:0]  commit_rd_q;
  logic [31:0]               commit_value_q, flush_pc_q;
  logic [ROB_SIZE_WIDTH:0]   commit_tag_q;

  logic                      commit_go, flush_go, alloc_go, cdb_hit;
  logic [ROB_SIZE_WIDTH-1:0] cdb_idx;

  assign rob_full_out = (count_q == FULL_CNT);
  assign rob_tail_out = {1'b0, tail_q};
  assign cdb_idx      = cdb_tag_in[ROB_SIZE_WIDTH-1:0];

  assign commit_go = busy_q[head_q] && ready_q[head_q];
  assign flush_go  = commit_go && (kind_q[head_q] == KIND_BRANCH) && mispred_q[head_q];
  assign alloc_go  = dec_valid_in && !rob_full_out && !flush_go;
  assign cdb_hit   = cdb_valid_in && (cdb_tag_in != NO_DEP) && busy_q[cdb_idx];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    if (flush_go) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      busy_d  = '0;
    end else begin
      if (commit_go) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + 1'b1;
      end
      if (alloc_go) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = 1'b0;
        tail_d          = tail_q + 1'b1;
      end
      if (cdb_hit) ready_d[cdb_idx] = 1'b1;
      // Simultaneous allocate and retire cancel out.
      if (alloc_go && !commit_go)      count_d = count_q + 1'b1;
      else if (commit_go && !alloc_go) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      ready_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_tag_q   <= '0;
      store_commit_q <= 1'b0;
      need_flush_q   <= 1'b0;
      flush_pc_q     <= '0;
    end else if (rdy_in) begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      commit_valid_q <= commit_go && (kind_q[head_q] == KIND_REG);
      store_commit_q <= commit_go && (kind_q[head_q] == KIND_STORE);
      need_flush_q   <= flush_go;
      if (commit_go && (kind_q[head_q] == KIND_REG)) begin
        commit_rd_q    <= rd_q[head_q];
        commit_value_q <= value_q[head_q];
        commit_tag_q   <= {1'b0, head_q};
      end
      if (flush_go) flush_pc_q <= target_q[head_q];
    end
  end

  // Entry payload carries no reset; busy/ready gate every use of it.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush_go) begin
      if (alloc_go) begin
        kind_q[tail_q] <= rob_kind_e'(dec_kind_in);
        rd_q[tail_q]   <= dec_rd_in;
      end
      if (cdb_hit) begin
        value_q[cdb_idx]   <= cdb_value_in;
        mispred_q[cdb_idx] <= cdb_mispredict_in;
        target_q[cdb_idx]  <= cdb_target_in;
      end
    end
  end

  rob_query #(.ROB_SIZE_WIDTH(ROB_SIZE_WIDTH)) u_qry1 (
    .tag_i         (qry1_tag_in),
    .entry_ready_i (ready_q),
    .entry_value_i (value_q),
    .cdb_valid_i   (cdb_valid_in),
    .cdb_tag_i     (cdb_tag_in),
    .cdb_value_i   (cdb_value_in),
    .ready_o       (qry1_ready_out),
    .value_o       (qry1_value_out)
  );

  rob_query #(.ROB_SIZE_WIDTH(ROB_SIZE_WIDTH)) u_qry2 (
    .tag_i         (qry2_tag_in),
    .entry_ready_i (ready_q),
    .entry_value_i (value_q),
    .cdb_valid_i   (cdb_valid_in),
    .cdb_tag_i     (cdb_tag_in),
    .cdb_value_i   (cdb_value_in),
    .ready_o       (qry2_ready_out),
    .value_o       (qry2_value_out)
  );

  assign commit_valid_out = commit_valid_q;
  assign commit_rd_out    = commit_rd_q;
  assign commit_value_out = commit_value_q;
  assign commit_tag_out   = commit_tag_q;
  assign store_commit_out = store_commit_q;
  assign need_flush_out   = need_flush_q;
  assign flush_pc_out     = flush_pc_q;

endmodule

// File: tb/tb_rob.sv
// Directed bench for the reorder buffer at ROB_SIZE_WIDTH=3, REG_NUM_WIDTH=5.
module tb_rob;

  logic        clk = 1'b0;
  logic        rst_n, rdy, dec_valid;
  logic [1:0]  dec_kind;
  logic [4:0]  dec_rd;
  logic        full;
  logic [3:0]  tail;
  logic        cdb_valid, cdb_mis;
  logic [3:0]  cdb_tag, q1_tag, q2_tag;
  logic [31:0] cdb_value, cdb_target;
  logic        q1_rdy, q2_rdy;
  logic [31:0] q1_val, q2_val;
  logic        c_valid, st_commit, flush;
  logic [4:0]  c_rd;
  logic [31:0] c_value, flush_pc;
  logic [3:0]  c_tag;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rob #(.ROB_SIZE_WIDTH(3), .REG_NUM_WIDTH(5)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
    .dec_valid_in(dec_valid), .dec_kind_in(dec_kind), .dec_rd_in(dec_rd),
    .rob_full_out(full), .rob_tail_out(tail),
    .cdb_valid_in(cdb_valid), .cdb_tag_in(cdb_tag), .cdb_value_in(cdb_value),
    .cdb_mispredict_in(cdb_mis), .cdb_target_in(cdb_target),
    .qry1_tag_in(q1_tag), .qry2_tag_in(q2_tag),
    .qry1_ready_out(q1_rdy), .qry2_ready_out(q2_rdy),
    .qry1_value_out(q1_val), .qry2_value_out(q2_val),
    .commit_valid_out(c_valid), .commit_rd_out(c_rd),
    .commit_value_out(c_value), .commit_tag_out(c_tag),
    .store_commit_out(st_commit), .need_flush_out(flush), .flush_pc_out(flush_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bcast(input logic [3:0] t, input logic [31:0] v,
                       input logic m, input logic [31:0] tgt);
    cdb_valid = 1'b1; cdb_tag = t; cdb_value = v; cdb_mis = m; cdb_target = tgt;
    tick();
    cdb_valid = 1'b0; cdb_mis = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; dec_valid = 1'b0; dec_kind = 2'd0; dec_rd = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; cdb_mis = 1'b0; cdb_target = '0;
    q1_tag = 4'hF; q2_tag = 4'hF;
    #12;
    chk("rst_full",   32'(full), 32'd0);
    chk("rst_tail",   32'(tail), 32'd0);
    chk("rst_cvalid", 32'(c_valid), 32'd0);
    chk("rst_store",  32'(st_commit), 32'd0);
    chk("rst_flush",  32'(flush), 32'd0);
    chk("rst_fpc",    flush_pc, 32'd0);
    rst_n = 1'b1;

    // Fill all eight entries, then a ninth request is ignored.
    dec_valid = 1'b1; dec_kind = 2'd0;
    for (int i = 0; i < 8; i++) begin
      dec_rd = 5'(i);
      chk("alloc_tag", 32'(tail), 32'(i));
      tick();
    end
    chk("full_after8", 32'(full), 32'd1);
    chk("tail_wrap",   32'(tail), 32'd0);
    tick();
    chk("ninth_tail", 32'(tail), 32'd0);
    chk("ninth_full", 32'(full), 32'd1);
    dec_valid = 1'b0;

    // Full ROB: head retires while a concurrent allocation is rejected.
    bcast(4'd0, 32'hAA, 1'b0, 32'h0);
    chk("full_nocommit_yet", 32'(c_valid), 32'd0);
    dec_valid = 1'b1;
    tick();
    chk("full_commit_v",   32'(c_valid), 32'd1);
    chk("full_commit_val", c_value, 32'hAA);
    chk("full_commit_rd",  32'(c_rd), 32'd0);
    chk("full_rej_full",   32'(full), 32'd0);
    chk("full_rej_tail",   32'(tail), 32'd0);
    tick();
    chk("refill_full", 32'(full), 32'd1);
    chk("refill_tail", 32'(tail), 32'd1);
    chk("pulse_end",   32'(c_valid), 32'd0);
    dec_valid = 1'b0;

    // Single REG entry through to commit, then a mid-run reset.
    do_reset();
    dec_valid = 1'b1; dec_kind = 2'd0; dec_rd = 5'd5;
    chk("b_tag0", 32'(tail), 32'd0);
    tick();
    dec_valid = 1'b0;
    bcast(4'd0, 32'h1234, 1'b0, 32'h0);
    chk("b_no_early", 32'(c_valid), 32'd0);
    tick();
    chk("b_cvalid", 32'(c_valid), 32'd1);
    chk("b_rd",     32'(c_rd), 32'd5);
    chk("b_value",  c_value, 32'h1234);
    chk("b_tag",    32'(c_tag), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_cvalid", 32'(c_valid), 32'd0);
    chk("arst_value",  c_value, 32'd0);
    chk("arst_rd",     32'(c_rd), 32'd0);
    chk("arst_tail",   32'(tail), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("arst_nopulse", 32'(c_valid), 32'd0);

    // Out-of-order completion, in-order retirement, and operand queries.
    dec_valid = 1'b1; dec_kind = 2'd0;
    for (int i = 0; i < 4; i++) begin
      dec_rd = 5'(i + 1);
      tick();
    end
    dec_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'h55;
    q1_tag = 4'd3; q2_tag = 4'd1;
    #1;
    chk("q1_fwd_rdy", 32'(q1_rdy), 32'd1);
    chk("q1_fwd_val", q1_val, 32'h55);
    chk("q2_not_rdy", 32'(q2_rdy), 32'd0);
    chk("q2_zero",    q2_val, 32'd0);
    tick();
    cdb_valid = 1'b0;
    q2_tag = 4'hF;
    #1;
    chk("q1_entry_rdy", 32'(q1_rdy), 32'd1);
    chk("q1_entry_val", q1_val, 32'h55);
    chk("q2_nodep",     32'(q2_rdy), 32'd0);
    q1_tag = 4'hF;
    bcast(4'd2, 32'h22, 1'b0, 32'h0);
    tick();
    chk("ooo_wait1", 32'(c_valid), 32'd0);
    bcast(4'd1, 32'h11, 1'b0, 32'h0);
    chk("ooo_wait2", 32'(c_valid), 32'd0);
    bcast(4'd0, 32'h10, 1'b0, 32'h0);
    chk("ooo_wait3", 32'(c_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_v [4];
      exp_v = '{32'h10, 32'h11, 32'h22, 32'h55};
      tick();
      chk("ooo_cvalid", 32'(c_valid), 32'd1);
      chk("ooo_tag",    32'(c_tag), 32'(i));
      chk("ooo_value",  c_value, exp_v[i]);
    end
    tick();
    chk("ooo_drain", 32'(c_valid), 32'd0);

    // Stall holds state; then STORE, good BRANCH, mispredicted BRANCH.
    do_reset();
    rdy = 1'b0; dec_valid = 1'b1; dec_kind = 2'd0;
    tick();
    chk("stall_tail", 32'(tail), 32'd0);
    rdy = 1'b1;
    dec_kind = 2'd2; tick();
    dec_kind = 2'd1; tick();
    dec_kind = 2'd1; tick();
    dec_kind = 2'd0; tick();
    dec_valid = 1'b0;
    chk("d_tail4", 32'(tail), 32'd4);
    bcast(4'd0, 32'h0, 1'b0, 32'h0);
    bcast(4'd1, 32'h0, 1'b0, 32'h40);
    chk("store_pulse", 32'(st_commit), 32'd1);
    chk("store_no_cv", 32'(c_valid), 32'd0);
    bcast(4'd2, 32'h0, 1'b1, 32'h80);
    chk("br_ok_store", 32'(st_commit), 32'd0);
    chk("br_ok_cv",    32'(c_valid), 32'd0);
    chk("br_ok_flush", 32'(flush), 32'd0);
    dec_valid = 1'b1; dec_kind = 2'd0; dec_rd = 5'd7;
    tick();
    dec_valid = 1'b0;
    chk("flush_pulse", 32'(flush), 32'd1);
    chk("flush_pc",    flush_pc, 32'h80);
    chk("flush_tail",  32'(tail), 32'd0);
    chk("flush_full",  32'(full), 32'd0);
    tick();
    chk("flush_end", 32'(flush), 32'd0);
    dec_valid = 1'b1; dec_rd = 5'd9;
    tick();
    dec_valid = 1'b0;
    bcast(4'd0, 32'h99, 1'b0, 32'h0);
    tick();
    chk("post_flush_cv",  32'(c_valid), 32'd1);
    chk("post_flush_tag", 32'(c_tag), 32'd0);
    chk("post_flush_rd",  32'(c_rd), 32'd9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
